led_strip_ctrl: RTL and testbench

LED_STRIP_CTRL -- requirements
Module: led_strip_ctrl

---
 rtl/led_strip_ctrl.sv | 169 ++++++++++++++++
 tb/tb_led_strip_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_strip_ctrl.sv
// Addressable LED strip frame sequencer: fetches each pixel, feeds it to the bit encoder, then holds the line latch.
// One pix_rd -> LOAD -> shift per LED, then RST_CYCLES of latch; no upstream backpressure, the sr_done handshake paces each word.
module led_strip_ctrl #(
  parameter int N_LEDS     = 64,
  parameter int W          = 24,
  parameter int BIT_CYCLES = 63,
  parameter int RST_CYCLES = 2500,
  localparam int AW        = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          frame_done,
  output logic          err,
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  input  logic [W-1:0]  pix_data,
  output logic          sr_en,
  output logic [W-1:0]  sr_data,
  input  logic          sr_done,
  output logic          latch
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int EW = $clog2(W + 3);
  localparam int LW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [EW-1:0] EN_MAX    = EW'(W + 2);
  localparam logic [LW-1:0] LAT_LAST  = LW'(RST_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(N_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   led_idx;
  logic [TW-1:0]   tick;
  logic [EW-1:0]   en_cnt;
  logic [LW-1:0]   lat_cnt;
  logic            normal_end;

  logic            start_ok;
  logic            done_ok;
  logic            wdog;
  logic            idx_last;
  logic            lat_last;

  assign idx_last = (led_idx == IDX_LAST);
  assign lat_last = (lat_cnt == LAT_LAST);
  assign start_ok = (state == S_IDLE) && start && !abort;

  // A done level seen in the same cycle as an enable, or before any enable, is left over from the previous word.
  assign done_ok  = (state == S_SHIFT) && !abort && sr_done && !sr_en && (en_cnt != '0);
  assign wdog     = (state == S_SHIFT) && !abort && !done_ok && (en_cnt == EN_MAX);

  assign pix_addr = led_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = abort ? S_LATCH : S_LOAD;
      end
      S_LOAD: begin
        state_nxt = abort ? S_LATCH : S_SHIFT;
      end
      S_SHIFT: begin
        if (abort || wdog)  state_nxt = S_LATCH;
        else if (done_ok)   state_nxt = idx_last ? S_LATCH : S_FETCH;
      end
      S_LATCH: begin
        if (lat_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    pix_rd = (state == S_FETCH) && !abort;
    sr_en  = (state == S_SHIFT) && !abort && (tick == '0);
    latch  = (state == S_LATCH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_idx <= '0;
    end else if (start_ok) begin
      led_idx <= '0;
    end else if (done_ok && !idx_last) begin
      led_idx <= led_idx + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_data <= '0;
    end else if ((state == S_LOAD) && !abort) begin
      sr_data <= pix_data;
    end
  end

  // Bit-period tick and per-word enable count; both restart at every LOAD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick   <= '0;
      en_cnt <= '0;
    end else if (state == S_LOAD) begin
      tick   <= '0;
      en_cnt <= '0;
    end else if (state == S_SHIFT) begin
      tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
      if (sr_en && (en_cnt != EN_MAX)) en_cnt <= en_cnt + EW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_cnt <= '0;
    end else if (state != S_LATCH) begin
      lat_cnt <= '0;
    end else if (!lat_last) begin
      lat_cnt <= lat_cnt + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (start_ok) begin
      err <= 1'b0;
    end else if (wdog) begin
      err <= 1'b1;
    end
  end

  // Only a frame that reached its last LED earns frame_done; abort and watchdog exits never set this.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      normal_end <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (start_ok)                  normal_end <= 1'b0;
      else if (done_ok && idx_last)  normal_end <= 1'b1;
      frame_done <= (state == S_LATCH) && lat_last && normal_end;
    end
  end

endmodule

// File: tb/tb_led_strip_ctrl.sv
// Directed bench for led_strip_ctrl with a behavioural shift-register model (25 enables per word).
module tb_led_strip_ctrl;

  localparam int N  = 3;
  localparam int WW = 24;
  localparam int BC = 4;
  localparam int RC = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, frame_done, err, pix_rd, sr_en, sr_done, latch;
  logic [1:0]  pix_addr;
  logic [23:0] pix_data = '0;
  logic [23:0] sr_data;

  led_strip_ctrl #(.N_LEDS(N), .W(WW), .BIT_CYCLES(BC), .RST_CYCLES(RC)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .busy(busy),
    .frame_done(frame_done), .err(err), .pix_rd(pix_rd), .pix_addr(pix_addr),
    .pix_data(pix_data), .sr_en(sr_en), .sr_data(sr_data), .sr_done(sr_done),
    .latch(latch)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [3];
  int          mode = 0;
  logic        m_done;
  int          m_cnt;

  assign sr_done = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : m_done;

  always @(posedge clk) if (pix_rd) pix_data <= mem[pix_addr];

  // Shift-register model: the 25th enable of a word raises done; the next enable clears it.
  always @(posedge clk or negedge rstn) begin
    if (!rstn || latch) begin
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (sr_en) begin
      if (m_cnt + 1 == WW + 1) begin
        m_done <= 1'b1;
        m_cnt  <= 0;
      end else begin
        m_done <= 1'b0;
        m_cnt  <= m_cnt + 1;
      end
    end
  end

  int          cyc = 0, n_busy = 0, n_rd = 0, n_en = 0, n_both = 0, n_lat = 0, n_fd = 0;
  int          gap_bad = 0, dat_bad = 0, last_en = 0;
  logic [5:0]  cur_w = '0;
  logic [1:0]  rd_addr [64];
  int          rd_cyc  [64];
  int          en1_cyc [64];
  int          wcnt    [64];
  logic [23:0] wdat    [64];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (busy)            n_busy <= n_busy + 1;
    if (latch)           n_lat  <= n_lat + 1;
    if (frame_done)      n_fd   <= n_fd + 1;
    if (pix_rd && sr_en) n_both <= n_both + 1;
    if (pix_rd) begin
      n_rd               <= n_rd + 1;
      cur_w              <= n_rd[5:0];
      rd_addr[n_rd[5:0]] <= pix_addr;
      rd_cyc[n_rd[5:0]]  <= cyc;
      wcnt[n_rd[5:0]]    <= 0;
    end
    if (sr_en) begin
      n_en        <= n_en + 1;
      last_en     <= cyc;
      wcnt[cur_w] <= wcnt[cur_w] + 1;
      if (wcnt[cur_w] == 0) begin
        wdat[cur_w]    <= sr_data;
        en1_cyc[cur_w] <= cyc;
      end else begin
        if (cyc - last_en != BC)    gap_bad <= gap_bad + 1;
        if (sr_data != wdat[cur_w]) dat_bad <= dat_bad + 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int b_rd, b_en, b_lat, b_fd, b_busy;

  task automatic snap();
    b_rd = n_rd; b_en = n_en; b_lat = n_lat; b_fd = n_fd; b_busy = n_busy;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output logic fd_first);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < budget);
    fd_first = frame_done;
    chk("idle_timeout", 32'(k >= budget), 0);
    @(posedge clk); #2;
  endtask

  logic fd1;
  int   k;

  initial begin
    mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h0000FF;

    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({frame_done, err, pix_rd, sr_en, latch}), 0);
    chk("rst_addr", 32'(pix_addr), 0);
    chk("rst_data", 32'(sr_data), 0);
    #20 rstn = 1'b1;

    // Normal frame
    snap();
    pulse_start();
    wait_idle(2000, fd1);
    chk("t1_fd_first_idle", 32'(fd1), 1);
    chk("t1_rd_cnt", n_rd - b_rd, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_rd_addr", 32'(rd_addr[b_rd + i]), i);
      chk("t1_sr_data", 32'(wdat[b_rd + i]), 32'(mem[i]));
      chk("t1_word_en", wcnt[b_rd + i], 25);
    end
    chk("t1_first_en_lat", en1_cyc[b_rd] - rd_cyc[b_rd], 2);
    chk("t1_en_total", n_en - b_en, 75);
    chk("t1_latch_cyc", n_lat - b_lat, RC);
    chk("t1_frame_done", n_fd - b_fd, 1);
    chk("t1_busy_cyc", n_busy - b_busy, 310);
    chk("t1_err", 32'(err), 0);

    // Done held high throughout: only the post-enable done is accepted
    mode = 2;
    snap();
    pulse_start();
    wait_idle(2000, fd1);
    mode = 0;
    chk("t2_fd_first_idle", 32'(fd1), 1);
    chk("t2_rd_cnt", n_rd - b_rd, 3);
    chk("t2_en_total", n_en - b_en, 3);
    chk("t2_busy_cyc", n_busy - b_busy, 22);

    // Watchdog
    mode = 1;
    snap();
    pulse_start();
    wait_idle(2000, fd1);
    chk("t3_fd_first_idle", 32'(fd1), 0);
    chk("t3_en_total", n_en - b_en, 26);
    chk("t3_rd_cnt", n_rd - b_rd, 1);
    chk("t3_latch_cyc", n_lat - b_lat, RC);
    chk("t3_frame_done", n_fd - b_fd, 0);
    chk("t3_busy_cyc", n_busy - b_busy, 114);
    repeat (3) @(posedge clk);
    #2 chk("t3_err_sticky", 32'(err), 1);
    mode = 0;
    pulse_start();
    chk("t3_err_cleared", 32'(err), 0);
    wait_idle(2000, fd1);
    chk("t3_next_frame_fd", 32'(fd1), 1);

    // Abort in word 1 SHIFT, on a cycle that would have carried sr_en
    pulse_start();
    k = 0;
    do begin @(negedge clk); k++; end while (!(pix_rd && pix_addr == 2'd1) && k < 500);
    do begin @(negedge clk); k++; end while (!sr_en && k < 500);
    chk("t4_wait_timeout", 32'(k >= 500), 0);
    repeat (4) @(posedge clk);
    #2 abort = 1'b1;
    snap();
    @(negedge clk);
    chk("t4_abort_sren", 32'(sr_en), 0);
    chk("t4_abort_pixrd", 32'(pix_rd), 0);
    @(posedge clk); #2;
    chk("t4_latch_next", 32'(latch), 1);
    repeat (3) @(posedge clk);
    #2 abort = 1'b0;
    wait_idle(200, fd1);
    chk("t4_en_after", n_en - b_en, 0);
    chk("t4_rd_after", n_rd - b_rd, 0);
    chk("t4_latch_cyc", n_lat - b_lat, RC);
    chk("t4_frame_done", n_fd - b_fd, 0);
    chk("t4_busy_fell", 32'(busy), 0);

    // start+abort in IDLE, then start while busy
    snap();
    @(posedge clk); #2 start = 1'b1; abort = 1'b1;
    @(posedge clk); #2 start = 1'b0; abort = 1'b0;
    chk("t5_idle_abort_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #2 chk("t5_idle_abort_rd", n_rd - b_rd, 0);
    snap();
    pulse_start();
    repeat (50) @(posedge clk);
    #2 start = 1'b1;
    repeat (2) @(posedge clk);
    #2 start = 1'b0;
    chk("t5_busy_kept", 32'(busy), 1);
    wait_idle(2000, fd1);
    chk("t5_rd_cnt", n_rd - b_rd, 3);
    chk("t5_busy_cyc", n_busy - b_busy, 310);
    chk("t5_frame_done", n_fd - b_fd, 1);

    // Reset mid-SHIFT of word 1
    pulse_start();
    repeat (120) @(posedge clk);
    #2 chk("t6_pre_addr", 32'(pix_addr), 1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_flags", 32'({frame_done, err, pix_rd, sr_en, latch}), 0);
    chk("t6_rst_addr", 32'(pix_addr), 0);
    chk("t6_rst_data", 32'(sr_data), 0);
    #10 rstn = 1'b1;
    @(posedge clk); #2;
    snap();
    repeat (30) @(posedge clk);
    #2;
    chk("t6_post_busy", n_busy - b_busy, 0);
    chk("t6_post_rd", n_rd - b_rd, 0);
    chk("t6_post_latch", n_lat - b_lat, 0);
    chk("t6_post_fd", n_fd - b_fd, 0);

    chk("all_rd_en_overlap", n_both, 0);
    chk("all_en_spacing", gap_bad, 0);
    chk("all_sr_data_stable", dat_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
